// File: rtl/addsub_result_fifo_if.sv
// Handshake bundle between addr_subtr, the sign-magnitude result FIFO and its sink.
// The FIFO uses the slave modport; the upstream/sink environment uses master.
interface addsub_result_fifo_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_diff;
  logic             br_ca_out;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_mag;
  logic             out_neg;
  logic             out_mode;
  logic [AW:0]      count;

  modport master (
    output in_valid, sum_diff, br_ca_out, mode, out_ready,
    input  in_ready, out_valid, out_mag, out_neg, out_mode, count
  );

  modport slave (
    input  in_valid, sum_diff, br_ca_out, mode, out_ready,
    output in_ready, out_valid, out_mag, out_neg, out_mode, count
  );
endinterface

// File: rtl/addsub_result_fifo.sv
// Converts addr_subtr results to sign-magnitude form and queues them in a small
// valid/ready FIFO so the sink never has to re-derive a negative magnitude.
module addsub_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic                 clk,
  input logic                 rst,
  addsub_result_fifo_if.slave bus
);

  localparam int            EW   = WIDTH + 3;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [EW-1:0]  mem_q [DEPTH];
  logic [EW-1:0]  head;
  logic           push, pop;
  logic [WIDTH:0] conv_mag;
  logic           conv_neg;

  always_comb begin
    conv_mag = {bus.br_ca_out, bus.sum_diff};
    conv_neg = 1'b0;
    if (bus.mode) begin
      if (bus.br_ca_out) begin
        conv_mag = {1'b0, bus.sum_diff};
      end else begin
        // A<B: the upstream difference is two's complement, so negate it back
        conv_mag = {1'b0, WIDTH'((~bus.sum_diff) + WIDTH'(1))};
        conv_neg = 1'b1;
      end
    end
    if (conv_mag == '0) begin
      conv_neg = 1'b0;
    end
  end

  // in_ready looks only at the registered count, so a full FIFO refuses a push
  // even when the sink pops in the same cycle.
  assign bus.in_ready  = (count_q != FULL);
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.mode, conv_neg, conv_mag};
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign bus.out_mag  = bus.out_valid ? head[WIDTH:0] : '0;
  assign bus.out_neg  = bus.out_valid & head[WIDTH+1];
  assign bus.out_mode = bus.out_valid & head[WIDTH+2];
  assign bus.count    = count_q;

endmodule

// File: tb/tb_addsub_result_fifo.sv
// Scoreboard bench for addsub_result_fifo: the driver queues hand-computed expected
// results on each accepted push, an independent monitor checks every pop in order.
module tb_addsub_result_fifo;

  typedef struct packed {
    logic [3:0] sd;
    logic       br;
    logic       m;
    logic [4:0] mag;
    logic       neg;
  } vec_t;

  typedef struct packed {
    logic [4:0] mag;
    logic       neg;
    logic       m;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  exp_t exp_q[$];
  logic t5_done;

  always #5 clk = ~clk;

  addsub_result_fifo_if #(.WIDTH(4), .AW(2)) bus ();

  addsub_result_fifo #(.WIDTH(4), .DEPTH(4), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t t5 [10] = '{
    '{4'h1, 1'b0, 1'b0, 5'd1,  1'b0},
    '{4'h2, 1'b1, 1'b0, 5'd18, 1'b0},
    '{4'h7, 1'b1, 1'b1, 5'd7,  1'b0},
    '{4'h9, 1'b0, 1'b1, 5'd7,  1'b1},
    '{4'hF, 1'b1, 1'b1, 5'd15, 1'b0},
    '{4'h1, 1'b0, 1'b1, 5'd15, 1'b1},
    '{4'h0, 1'b1, 1'b0, 5'd16, 1'b0},
    '{4'hA, 1'b0, 1'b0, 5'd10, 1'b0},
    '{4'hC, 1'b0, 1'b1, 5'd4,  1'b1},
    '{4'h6, 1'b1, 1'b1, 5'd6,  1'b0}
  };

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [3:0] sd, input logic br, input logic m,
                      input logic [4:0] mag, input logic neg);
    int  waits = 0;
    bit  done  = 0;
    exp_t e;
    bus.sum_diff  = sd;
    bus.br_ca_out = br;
    bus.mode      = m;
    bus.in_valid  = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.mag = mag; e.neg = neg; e.m = m;
        exp_q.push_back(e);
        done = 1;
      end else if (waits > 100) begin
        total++;
        $display("FAIL send_timeout: in_ready stuck at 0 for sd=%0h", sd);
        done = 1;
      end
      waits++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    $display("push sd=%0h br=%0d mode=%0d -> expect mag=%0d neg=%0d", sd, br, m, mag, neg);
  endtask

  task automatic sendv(input vec_t v);
    send(v.sd, v.br, v.m, v.mag, v.neg);
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    bus.out_ready = 1'b0;
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", int'(bus.out_valid), 0);
  endtask

  // Monitor: a pop happens at the next posedge whenever out_valid & out_ready here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL pop_unexpected: mag=%0d neg=%0d with empty scoreboard",
                   bus.out_mag, bus.out_neg);
        end else begin
          e = exp_q.pop_front();
          $display("pop mag=%0d neg=%0d mode=%0d (expect %0d/%0d/%0d)",
                   bus.out_mag, bus.out_neg, bus.out_mode, e.mag, e.neg, e.m);
          check("pop_mag", int'(bus.out_mag), int'(e.mag));
          check("pop_neg", int'(bus.out_neg), int'(e.neg));
          check("pop_mode", int'(bus.out_mode), int'(e.m));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: reset held two edges with in_valid asserted
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sum_diff  = 4'hF;
    bus.br_ca_out = 1'b1;
    bus.mode      = 1'b1;
    bus.out_ready = 1'b0;
    t5_done       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_count", int'(bus.count), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_mag", int'(bus.out_mag), 0);
    check("rst_out_neg", int'(bus.out_neg), 0);
    check("rst_out_mode", int'(bus.out_mode), 0);
    @(posedge clk); #1;

    // T2: 15+15 visible right after the push edge
    send(4'hE, 1'b1, 1'b0, 5'd30, 1'b0);
    @(negedge clk);
    check("t2_out_valid", int'(bus.out_valid), 1);
    check("t2_count", int'(bus.count), 1);
    check("t2_out_mag", int'(bus.out_mag), 30);
    check("t2_out_neg", int'(bus.out_neg), 0);
    @(posedge clk); #1;
    drain();

    // T3: subtract results, including a zero difference
    send(4'h3, 1'b1, 1'b1, 5'd3, 1'b0);
    send(4'hD, 1'b0, 1'b1, 5'd3, 1'b1);
    send(4'h0, 1'b1, 1'b1, 5'd0, 1'b0);
    drain();

    // T4: fill to DEPTH, fifth held until a pop frees a slot
    send(4'h5, 1'b0, 1'b0, 5'd5,  1'b0);
    send(4'hF, 1'b1, 1'b0, 5'd31, 1'b0);
    send(4'h0, 1'b0, 1'b1, 5'd0,  1'b0);
    send(4'hF, 1'b0, 1'b1, 5'd1,  1'b1);
    @(negedge clk);
    check("t4_full_in_ready", int'(bus.in_ready), 0);
    check("t4_full_count", int'(bus.count), 4);
    @(posedge clk); #1;
    bus.sum_diff  = 4'h8;
    bus.br_ca_out = 1'b0;
    bus.mode      = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    check("t4_held_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    check("t4_held_count", int'(bus.count), 4);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_refuse_on_pop", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("t4_after_pop_count", int'(bus.count), 3);
    send(4'h8, 1'b0, 1'b1, 5'd8, 1'b1);
    check("t4_refill_count", int'(bus.count), 4);
    drain();

    // T5: ten entries with random gaps and random sink back-pressure
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          sendv(t5[i]);
        end
        t5_done = 1'b1;
      end
      begin
        while (!t5_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Simultaneous push and pop with count=2 leaves count unchanged
    send(4'h3, 1'b0, 1'b0, 5'd3,  1'b0);
    send(4'h4, 1'b1, 1'b0, 5'd20, 1'b0);
    bus.out_ready = 1'b1;
    send(4'hB, 1'b0, 1'b1, 5'd5, 1'b1);
    bus.out_ready = 1'b0;
    check("simul_count", int'(bus.count), 2);
    drain();

    // T6: reset with three entries in flight discards them
    send(4'h2, 1'b0, 1'b0, 5'd2, 1'b0);
    send(4'h3, 1'b0, 1'b0, 5'd3, 1'b0);
    send(4'h4, 1'b0, 1'b0, 5'd4, 1'b0);
    check("t6_pre_count", int'(bus.count), 3);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_count", int'(bus.count), 0);
    check("t6_rst_out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    send(4'hE, 1'b0, 1'b1, 5'd2,  1'b1);
    send(4'h9, 1'b1, 1'b0, 5'd25, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
